// File: rtl/sc_player_position_register_if.sv
// Player position bus: the shift/load/obstacle inputs coming from the player
// state machine and the displayed row, edge flags and collision flag going back.
interface sc_player_position_register_if #(
  parameter int DATAWIDTH = 8
);
  logic [1:0]           ShiftSelection_In;
  logic                 Load_InLow;
  logic [DATAWIDTH-1:0] ObstacleRow_In;
  logic [DATAWIDTH-1:0] Position_Out;
  logic                 AtLeftEdge_Out;
  logic                 AtRightEdge_Out;
  logic                 Collision_OutLow;

  // Upstream side: drives shift codes, level load and obstacle row.
  modport master (
    output ShiftSelection_In,
    output Load_InLow,
    output ObstacleRow_In,
    input  Position_Out,
    input  AtLeftEdge_Out,
    input  AtRightEdge_Out,
    input  Collision_OutLow
  );

  // Position register side.
  modport slave (
    input  ShiftSelection_In,
    input  Load_InLow,
    input  ObstacleRow_In,
    output Position_Out,
    output AtLeftEdge_Out,
    output AtRightEdge_Out,
    output Collision_OutLow
  );
endinterface

// File: rtl/sc_player_position_register.sv
// Player column position on the player row of the LED matrix.
// Moves one column per shift code, saturating at both edges, detects overlap
// with the obstacle row, and after a hit freezes and blinks the player bit
// until the next level load. Collision_OutLow feeds back as PlayerLose.
module sc_player_position_register #(
  parameter int                   DATAWIDTH     = 8,
  parameter logic [DATAWIDTH-1:0] INIT_POSITION = DATAWIDTH'(8'b0001_0000),
  parameter int                   BLINK_TICKS   = 12_500_000
) (
  input  logic                           SC_PLAYER_STATEMACHINE_CLOCK_50,
  input  logic                           SC_PLAYER_STATEMACHINE_RESET_InHigh,
  sc_player_position_register_if.slave   playerBus
);

  // A counter of at least one bit even when a blink half-period is one clock.
  localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CNT_W-1:0]     BLINK_LAST = CNT_W'(BLINK_TICKS - 1);
  localparam logic [DATAWIDTH-1:0] LEFT_EDGE  = DATAWIDTH'(1) << (DATAWIDTH - 1);
  localparam logic [DATAWIDTH-1:0] RIGHT_EDGE = DATAWIDTH'(1);

  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // Two-hot-free encodings so a corrupted state register is detectable.
  typedef enum logic [1:0] {
    ALIVE = 2'b01,
    HIT   = 2'b10
  } state_t;

  state_t               state;
  logic [DATAWIDTH-1:0] position;
  logic [CNT_W-1:0]     blinkCount;
  logic                 blinkPhase;

  // Saturating one-column move; the bit is never shifted out, so the
  // position stays one-hot.
  function automatic logic [DATAWIDTH-1:0] shiftPosition(
    input logic [DATAWIDTH-1:0] pos,
    input logic [1:0]           code
  );
    logic [DATAWIDTH-1:0] result;
    result = pos;
    case (code)
      SHIFT_LEFT:  if (!pos[DATAWIDTH-1]) result = pos << 1;
      SHIFT_RIGHT: if (!pos[0])           result = pos >> 1;
      default:     result = pos;
    endcase
    return result;
  endfunction

  // Player state machine: load has priority, then collision, then movement;
  // in HIT the position is frozen and the blink phase toggles every BLINK_TICKS.
  always_ff @(posedge SC_PLAYER_STATEMACHINE_CLOCK_50 or
              posedge SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
    if (SC_PLAYER_STATEMACHINE_RESET_InHigh) begin
      state      <= ALIVE;
      position   <= INIT_POSITION;
      blinkCount <= '0;
      blinkPhase <= 1'b1;
    end else begin
      case (state)
        ALIVE: begin
          if (!playerBus.Load_InLow) begin
            position   <= INIT_POSITION;
            blinkCount <= '0;
            blinkPhase <= 1'b1;
          end else if (|(position & playerBus.ObstacleRow_In)) begin
            // Position is frozen and this cycle's shift code is dropped.
            state      <= HIT;
            blinkCount <= '0;
            blinkPhase <= 1'b0;
          end else begin
            position <= shiftPosition(position, playerBus.ShiftSelection_In);
          end
        end
        HIT: begin
          if (!playerBus.Load_InLow) begin
            state      <= ALIVE;
            position   <= INIT_POSITION;
            blinkCount <= '0;
            blinkPhase <= 1'b1;
          end else if (blinkCount == BLINK_LAST) begin
            blinkCount <= '0;
            blinkPhase <= ~blinkPhase;
          end else begin
            blinkCount <= blinkCount + CNT_W'(1);
          end
        end
        default: begin
          // Recover from an illegal state encoding as if a level had loaded.
          state      <= ALIVE;
          position   <= INIT_POSITION;
          blinkCount <= '0;
          blinkPhase <= 1'b1;
        end
      endcase
    end
  end

  // Output decode straight from registers: blinked row in HIT, edge flags
  // from the internal (unblinked) position, collision flag from the state.
  always_comb begin
    playerBus.Position_Out     = position;
    playerBus.Collision_OutLow = 1'b1;
    if (state == HIT) begin
      playerBus.Position_Out     = position & {DATAWIDTH{blinkPhase}};
      playerBus.Collision_OutLow = 1'b0;
    end
    playerBus.AtLeftEdge_Out  = (position == LEFT_EDGE);
    playerBus.AtRightEdge_Out = (position == RIGHT_EDGE);
  end

endmodule

// File: doc/sc_player_position_register.md
Name: sc_player_position_register

Overview:
- Holds the player's one-hot column position on the player row of the LED matrix.
- Sits directly downstream of the player state machine and consumes its 2-bit shift-selection code: shift left, shift right or hold.
- Compares the position against the obstacle row and raises a registered active-low collision flag. This flag feeds back as the state machine's PlayerLose input.
- After a hit it freezes the position and blinks the player bit until the next level load.

Parameters:
- DATAWIDTH, 8, width of the player row; one bit per column.
- INIT_POSITION, 8'b0001_0000, one-hot position loaded at reset and on level load. Exactly one bit is set.
- BLINK_TICKS, 12_500_000, clock cycles per blink half-period in HIT state. Must be ≥1.

Ports:
- SC_PLAYER_STATEMACHINE_CLOCK_50  in  1  system clock, 50 MHz, rising edge.
- SC_PLAYER_STATEMACHINE_RESET_InHigh  in  1  asynchronous, active-high reset.
- ShiftSelection_In  in  2  shift code: 00 hold, 01 left (toward MSB), 10 right (toward LSB), 11 hold.
- Load_InLow  in  1  level (re)start; active low, sampled each clock.
- ObstacleRow_In  in  DATAWIDTH  obstacle occupancy of the player row; 1 means an obstacle is in that column.
- Position_Out  out  DATAWIDTH  displayed player row; blinks in HIT state.
- AtLeftEdge_Out  out  1  high when the internal position equals MSB one-hot.
- AtRightEdge_Out  out  1  high when the internal position equals LSB one-hot.
- Collision_OutLow  out  1  low while in HIT state; connects to PlayerLose_InLow upstream.

Behaviour:
Reset (asynchronous, active high):
- State = ALIVE, position register = INIT_POSITION, blink counter = 0, blink phase = 1.
- Outputs after reset: Position_Out = INIT_POSITION, Collision_OutLow = 1, edge flags decoded from INIT_POSITION.
- Reset asserted mid-operation, in any state, forces the values above immediately.

State machine (Moore, 2 states):
- ALIVE, in priority order per clock:
  1. Load_InLow = 0: position <= INIT_POSITION; stay ALIVE.
  2. (position & ObstacleRow_In) != 0: go to HIT; position frozen; shift code ignored this cycle; blink counter = 0; phase = 0.
  3. Otherwise apply the shift code:
     - 01: position <<= 1, unless position[DATAWIDTH-1] = 1 (saturate, hold).
     - 10: position >>= 1, unless position[0] = 1 (saturate, hold).
     - 00 or 11: hold.
- HIT:
  - Shift codes are ignored and the position is frozen.
  - The blink counter counts 0..BLINK_TICKS-1; on wrap it returns to 0 and the phase toggles.
  - Load_InLow = 0: go to ALIVE, position <= INIT_POSITION, phase = 1, counter = 0.
- Unreachable state encodings recover to ALIVE with INIT_POSITION.

Outputs:
- Collision_OutLow = 0 iff state = HIT. Registered, so the effective latency is 1 clock from the overlap cycle.
- Position_Out = position in ALIVE; position & {DATAWIDTH{phase}} in HIT.
- Edge flags decode the internal position, not the blinked output.

Invariants and timing:
- The position register is always exactly one-hot; no shift may lose or duplicate the bit.
- A shift takes effect on Position_Out one clock after the code is sampled.
- The upstream FSM emits a shift code for exactly 1 cycle per press, so one press moves the player exactly one column.

Test Plan:
- Reset, then hold 00 for 5 clocks -> Position_Out = 8'h10, Collision_OutLow = 1, both edge flags 0.
- Pulse 01 four times, one cycle each, with 00 between pulses -> 8'h20, 8'h40, 8'h80, then held at 8'h80 (saturated); AtLeftEdge_Out = 1 after the third pulse.
- From 8'h01, apply 10 for 3 consecutive cycles -> stays 8'h01, AtRightEdge_Out = 1; code 11 also holds.
- Position 8'h10, ObstacleRow_In = 8'h10 with 01 applied the same cycle -> next clock HIT, Collision_OutLow = 0, internal position stays 8'h10 (shift ignored), Position_Out = 8'h00. With BLINK_TICKS = 4 in the bench, Position_Out alternates 8'h10/8'h00 every 4 clocks; shift codes have no effect.
- In HIT, pulse Load_InLow = 0 for 1 clock -> ALIVE, Position_Out = 8'h10, Collision_OutLow = 1. Separately, Load_InLow = 0 together with an overlapping obstacle in ALIVE -> load wins and the state stays ALIVE for that cycle.
- Assert reset asynchronously mid-blink, between clock edges -> outputs are immediately 8'h10, Collision_OutLow = 1, state ALIVE.
